flag_pipe: RTL and testbench
============================

FLAG_PIPE -- requirements
Module: flag_pipe

Interface
REQ-001 Parameter: RESET_SR, 4'b0000, status-register value loaded on reset; bit order {z,c,n,v}.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 id_valid  in  1  decode stage holds an instruction.
REQ-005 id_cond  in  4  condition field of decoded instruction.
REQ-006 id_s_bit  in  1  decoded instruction updates flags.
REQ-007 id_flush  in  1  insert bubble into EX instead of decode contents.
REQ-008 ex_stall  in  1  hold EX stage contents.
REQ-009 ex_cond_pass  in  1  condition-check result for ex_cond/ex_sr, same cycle.
REQ-010 alu_flags  in  4  ALU result flags {z,c,n,v} for the EX instruction.
REQ-011 msr_req  in  1  request to write status register directly; held until acked.
REQ-012 msr_data  in  4  value for direct write {z,c,n,v}.
REQ-013 ex_valid  out  1  EX stage holds an instruction.
REQ-014 ex_cond  out  4  condition field of EX instruction, to condition check.
REQ-015 ex_sr  out  4  forwarded flags {z,c,n,v}, to condition check.
REQ-016 ex_exec  out  1  EX instruction valid and condition passed.
REQ-017 sr_q  out  4  architectural status register {z,c,n,v}.
REQ-018 msr_ack  out  1  direct write accepted this cycle.
REQ-019 flags_busy  out  1  flag writeback pending in WB stage.

Function
REQ-020 Pipeline SHALL have two flag stages: EX register (ex_valid, ex_cond, ex_s_bit) and WB register (wb_pend, wb_flags).
REQ-021 EX load priority SHALL be: id_flush -> ex_valid=0, ex_cond=4'b1111, ex_s_bit=0; else ex_stall -> hold; else load id_valid/id_cond/id_s_bit.
REQ-022 id_flush SHALL take effect even when ex_stall=1.
REQ-023 ex_exec SHALL equal ex_valid & ex_cond_pass, combinational.
REQ-024 capture = ex_exec & ex_s_bit & ~ex_stall; on capture, wb_flags<=alu_flags and wb_pend<=1 at next edge.
REQ-025 Without capture, wb_pend SHALL clear at next edge (WB advances a bubble); wb_flags holds.
REQ-026 When wb_pend=1, sr_q SHALL load wb_flags at next edge; latency ALU result -> sr_q = 2 edges.
REQ-027 ex_sr SHALL equal wb_flags when wb_pend=1, else sr_q (back-to-back forwarding, no stall required).
REQ-028 flags_busy SHALL equal wb_pend.
REQ-029 msr_ack SHALL equal msr_req & ~ex_valid & ~wb_pend, combinational; on msr_ack, sr_q<=msr_data at next edge.
REQ-030 MSR write and WB write SHALL never coincide; msr_ack low while any flag producer is in flight.
REQ-031 Non-S or condition-failed instructions SHALL leave sr_q and wb_flags unchanged.
REQ-032 Stalled EX instruction SHALL not capture until the cycle ex_stall=0, re-evaluating ex_cond_pass then.
REQ-033 Flags width SHALL be exactly 4 bits; no flag bit derived inside this block.

Reset
REQ-034 On rst=1, asynchronously: ex_valid=0, ex_cond=4'b1111, ex_s_bit=0, wb_pend=0, wb_flags=0, sr_q=RESET_SR.
REQ-035 During reset, outputs SHALL be: ex_exec=0, msr_ack=0, flags_busy=0, ex_sr=RESET_SR.
REQ-036 Reset asserted mid-operation SHALL discard any pending WB update and unacked MSR request.

Verification
REQ-037 S-instr, cond pass, alu_flags=4'b1000 -> flags_busy=1 next cycle, sr_q=4'b1000 one cycle later.
REQ-038 Back-to-back: instr A sets flags 4'b0100, instr B in EX next cycle -> ex_sr=4'b0100 while sr_q still old.
REQ-039 S-instr with ex_cond_pass=0 -> sr_q, flags_busy unchanged (flags_busy=0).
REQ-040 msr_req=1, msr_data=4'b0011 with EX occupied -> msr_ack=0 until EX and WB empty, then one-cycle ack, sr_q=4'b0011.
REQ-041 ex_stall=1 with id_flush=1 -> ex_valid=0 next cycle; ex_stall alone -> EX contents held, no capture.
REQ-042 rst asserted while wb_pend=1 -> sr_q=RESET_SR immediately, pending flags never written.

Source files
------------

// File: rtl/flag_pipe.sv
// Condition-flag pipeline: EX and WB flag stages, forwarding of in-flight
// flags to the condition check, and the architectural status register.
module flag_pipe #(
  parameter logic [3:0] RESET_SR = 4'b0000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [3:0] id_cond,
  input  logic       id_s_bit,
  input  logic       id_flush,
  input  logic       ex_stall,
  input  logic       ex_cond_pass,
  input  logic [3:0] alu_flags,
  input  logic       msr_req,
  input  logic [3:0] msr_data,
  output logic       ex_valid,
  output logic [3:0] ex_cond,
  output logic [3:0] ex_sr,
  output logic       ex_exec,
  output logic [3:0] sr_q,
  output logic       msr_ack,
  output logic       flags_busy
);

  logic       ex_s_bit;
  logic       wb_pend;
  logic [3:0] wb_flags;
  logic       capture;

  assign ex_exec    = ex_valid & ex_cond_pass;
  assign capture    = ex_exec & ex_s_bit & ~ex_stall;
  assign flags_busy = wb_pend;
  assign ex_sr      = wb_pend ? wb_flags : sr_q;
  // Direct writes wait until no flag producer is in EX or WB, so they never race a writeback.
  assign msr_ack    = msr_req & ~ex_valid & ~wb_pend & ~rst;

  // Stage EX: flush beats stall beats load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid <= 1'b0;
      ex_cond  <= 4'b1111;
      ex_s_bit <= 1'b0;
    end else if (id_flush) begin
      ex_valid <= 1'b0;
      ex_cond  <= 4'b1111;
      ex_s_bit <= 1'b0;
    end else if (!ex_stall) begin
      ex_valid <= id_valid;
      ex_cond  <= id_cond;
      ex_s_bit <= id_s_bit;
    end
  end

  // Stage WB: holds the captured ALU flags for one cycle before commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_pend  <= 1'b0;
      wb_flags <= 4'b0000;
    end else begin
      wb_pend <= capture;
      if (capture) begin
        wb_flags <= alu_flags;
      end
    end
  end

  // Architectural status register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q <= RESET_SR;
    end else if (wb_pend) begin
      sr_q <= wb_flags;
    end else if (msr_ack) begin
      sr_q <= msr_data;
    end
  end

  assert property (@(posedge clk) disable iff (rst) !(wb_pend && msr_ack));

endmodule

// File: tb/tb_flag_pipe.sv
// Bench for flag_pipe: directed vector table, an asynchronous-reset sequence,
// and randomized traffic against a queue-based model of in-flight flag writes.
module tb_flag_pipe;

  localparam logic [3:0] RSR = 4'b0101;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_s_bit, id_flush, ex_stall, ex_cond_pass, msr_req;
  logic [3:0] id_cond, alu_flags, msr_data;
  logic       ex_valid, ex_exec, msr_ack, flags_busy;
  logic [3:0] ex_cond, ex_sr, sr_q;

  flag_pipe #(.RESET_SR(RSR)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_cond(id_cond),
    .id_s_bit(id_s_bit), .id_flush(id_flush), .ex_stall(ex_stall),
    .ex_cond_pass(ex_cond_pass), .alu_flags(alu_flags), .msr_req(msr_req),
    .msr_data(msr_data), .ex_valid(ex_valid), .ex_cond(ex_cond), .ex_sr(ex_sr),
    .ex_exec(ex_exec), .sr_q(sr_q), .msr_ack(msr_ack), .flags_busy(flags_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       rst, iv;
    logic [3:0] ic;
    logic       is, fl, st, pa;
    logic [3:0] alu;
    logic       mr;
    logic [3:0] md;
    logic       e_v, e_x;
    logic [3:0] e_sr, e_q;
    logic       e_ack, e_busy;
  } vec_t;

  vec_t tbl[21];

  // Reference model: EX contents, a queue of flag writes not yet committed, and the committed value.
  logic       m_v, m_s;
  logic [3:0] m_c, m_sr;
  logic [3:0] pq[$];

  task automatic model_reset();
    m_v = 1'b0; m_c = 4'hF; m_s = 1'b0; m_sr = RSR;
    pq.delete();
  endtask

  function automatic logic [3:0] newest_flags();
    return (pq.size() != 0) ? pq[pq.size()-1] : m_sr;
  endfunction

  function automatic logic pred_ack();
    return !rst && msr_req && !m_v && (pq.size() == 0);
  endfunction

  task automatic model_edge();
    logic ack_now;
    logic cap;
    ack_now = pred_ack();
    cap = m_v && ex_cond_pass && m_s && !ex_stall;
    if (pq.size() != 0) m_sr = pq.pop_front();
    else if (ack_now) m_sr = msr_data;
    if (cap) pq.push_back(alu_flags);
    if (id_flush) begin
      m_v = 1'b0; m_c = 4'hF; m_s = 1'b0;
    end else if (!ex_stall) begin
      m_v = id_valid; m_c = id_cond; m_s = id_s_bit;
    end
  endtask

  task automatic drive_idle();
    rst = 0; id_valid = 0; id_cond = 0; id_s_bit = 0; id_flush = 0; ex_stall = 0;
    ex_cond_pass = 0; alu_flags = 0; msr_req = 0; msr_data = 0;
  endtask

  initial begin
    logic hold_req;
    logic [3:0] hold_data;
    logic ack_seen;

    //          rst iv ic    is fl st pa alu   mr md     ev ex esr   sq    ack bsy
    tbl[0]  = '{1, 0, 4'h0, 0, 0, 0, 0, 4'h0, 1, 4'h3,  0, 0, 4'h5, 4'h5, 0, 0};
    tbl[1]  = '{0, 1, 4'h0, 1, 0, 0, 1, 4'h0, 0, 4'h0,  0, 0, 4'h5, 4'h5, 0, 0};
    tbl[2]  = '{0, 1, 4'h0, 1, 0, 0, 1, 4'h8, 0, 4'h0,  1, 1, 4'h5, 4'h5, 0, 0};
    tbl[3]  = '{0, 0, 4'h0, 0, 0, 0, 1, 4'h4, 0, 4'h0,  1, 1, 4'h8, 4'h5, 0, 1};
    tbl[4]  = '{0, 0, 4'h0, 0, 0, 0, 0, 4'h0, 0, 4'h0,  0, 0, 4'h4, 4'h8, 0, 1};
    tbl[5]  = '{0, 1, 4'h0, 1, 0, 0, 0, 4'h0, 0, 4'h0,  0, 0, 4'h4, 4'h4, 0, 0};
    tbl[6]  = '{0, 0, 4'h0, 0, 0, 0, 0, 4'hF, 0, 4'h0,  1, 0, 4'h4, 4'h4, 0, 0};
    tbl[7]  = '{0, 1, 4'h0, 1, 0, 0, 0, 4'h0, 0, 4'h0,  0, 0, 4'h4, 4'h4, 0, 0};
    tbl[8]  = '{0, 0, 4'h0, 0, 0, 1, 1, 4'h1, 0, 4'h0,  1, 1, 4'h4, 4'h4, 0, 0};
    tbl[9]  = '{0, 0, 4'h0, 0, 0, 1, 1, 4'h1, 0, 4'h0,  1, 1, 4'h4, 4'h4, 0, 0};
    tbl[10] = '{0, 1, 4'h0, 1, 0, 0, 0, 4'h1, 0, 4'h0,  1, 0, 4'h4, 4'h4, 0, 0};
    tbl[11] = '{0, 1, 4'h0, 1, 1, 1, 1, 4'hF, 0, 4'h0,  1, 1, 4'h4, 4'h4, 0, 0};
    tbl[12] = '{0, 1, 4'h0, 1, 0, 0, 1, 4'h0, 0, 4'h0,  0, 0, 4'h4, 4'h4, 0, 0};
    tbl[13] = '{0, 0, 4'h0, 0, 0, 0, 1, 4'h6, 1, 4'h3,  1, 1, 4'h4, 4'h4, 0, 0};
    tbl[14] = '{0, 0, 4'h0, 0, 0, 0, 0, 4'h0, 1, 4'h3,  0, 0, 4'h6, 4'h4, 0, 1};
    tbl[15] = '{0, 0, 4'h0, 0, 0, 0, 0, 4'h0, 1, 4'h3,  0, 0, 4'h6, 4'h6, 1, 0};
    tbl[16] = '{0, 1, 4'h0, 1, 0, 0, 0, 4'h0, 0, 4'h0,  0, 0, 4'h3, 4'h3, 0, 0};
    tbl[17] = '{0, 0, 4'h0, 0, 0, 0, 1, 4'hA, 0, 4'h0,  1, 1, 4'h3, 4'h3, 0, 0};
    tbl[18] = '{0, 0, 4'h0, 0, 0, 0, 0, 4'h0, 0, 4'h0,  0, 0, 4'hA, 4'h3, 0, 1};
    tbl[19] = '{1, 0, 4'h0, 0, 0, 0, 0, 4'h0, 0, 4'h0,  0, 0, 4'h5, 4'h5, 0, 0};
    tbl[20] = '{0, 0, 4'h0, 0, 0, 0, 0, 4'h0, 0, 4'h0,  0, 0, 4'h5, 4'h5, 0, 0};

    drive_idle();
    for (int i = 0; i < 21; i++) begin
      rst = tbl[i].rst; id_valid = tbl[i].iv; id_cond = tbl[i].ic; id_s_bit = tbl[i].is;
      id_flush = tbl[i].fl; ex_stall = tbl[i].st; ex_cond_pass = tbl[i].pa;
      alu_flags = tbl[i].alu; msr_req = tbl[i].mr; msr_data = tbl[i].md;
      @(negedge clk);
      chk($sformatf("vec%0d ex_valid", i), {3'b0, ex_valid}, {3'b0, tbl[i].e_v});
      chk($sformatf("vec%0d ex_exec", i), {3'b0, ex_exec}, {3'b0, tbl[i].e_x});
      chk($sformatf("vec%0d ex_sr", i), ex_sr, tbl[i].e_sr);
      chk($sformatf("vec%0d sr_q", i), sr_q, tbl[i].e_q);
      chk($sformatf("vec%0d msr_ack", i), {3'b0, msr_ack}, {3'b0, tbl[i].e_ack});
      chk($sformatf("vec%0d flags_busy", i), {3'b0, flags_busy}, {3'b0, tbl[i].e_busy});
      @(posedge clk); #1;
    end

    // Flush ex_cond value after a stalled flush
    drive_idle(); id_valid = 1; id_cond = 4'h3; id_s_bit = 1;
    @(posedge clk); #1;
    chk("load ex_cond", ex_cond, 4'h3);
    ex_stall = 1; id_flush = 1;
    @(posedge clk); #1;
    chk("flush ex_cond", ex_cond, 4'hF);
    chk("flush ex_valid", {3'b0, ex_valid}, 4'h0);

    // Asynchronous reset pulse between edges while a writeback is pending
    drive_idle(); id_valid = 1; id_s_bit = 1;
    @(posedge clk); #1;
    drive_idle(); ex_cond_pass = 1; alu_flags = 4'hC;
    @(posedge clk); #1;
    drive_idle();
    chk("async pre busy", {3'b0, flags_busy}, 4'h1);
    #1 rst = 1;
    #1;
    chk("async sr_q", sr_q, RSR);
    chk("async busy", {3'b0, flags_busy}, 4'h0);
    chk("async ex_sr", ex_sr, RSR);
    rst = 0;
    @(posedge clk); #1;
    chk("async discard", sr_q, RSR);

    // Randomized traffic against the model
    rst = 1;
    @(posedge clk); #1;
    model_reset();
    hold_req = 0; hold_data = 0;
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      id_valid = $urandom_range(0, 1);
      id_cond = 4'($urandom_range(0, 15));
      id_s_bit = $urandom_range(0, 1);
      id_flush = ($urandom_range(0, 7) == 0);
      ex_stall = ($urandom_range(0, 3) == 0);
      ex_cond_pass = $urandom_range(0, 1);
      alu_flags = 4'($urandom_range(0, 15));
      if (!hold_req && $urandom_range(0, 5) == 0) begin
        hold_req = 1; hold_data = 4'($urandom_range(0, 15));
      end
      msr_req = hold_req; msr_data = hold_data;
      if (rst) model_reset();
      @(negedge clk);
      ack_seen = pred_ack();
      chk("rnd ex_valid", {3'b0, ex_valid}, {3'b0, m_v});
      chk("rnd ex_cond", ex_cond, m_c);
      chk("rnd ex_exec", {3'b0, ex_exec}, {3'b0, m_v && ex_cond_pass});
      chk("rnd ex_sr", ex_sr, newest_flags());
      chk("rnd sr_q", sr_q, m_sr);
      chk("rnd msr_ack", {3'b0, msr_ack}, {3'b0, ack_seen});
      chk("rnd flags_busy", {3'b0, flags_busy}, {3'b0, pq.size() != 0});
      @(posedge clk);
      if (!rst) model_edge();
      if (ack_seen || rst) hold_req = 0;
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
